fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain_pkg.sv | 14 +
 rtl/fifo_drain_buf.sv | 76 +++++++
 rtl/fifo_drain.sv | 65 ++++++
 tb/tb_fifo_drain.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and default widths for the fifo_drain slice.
// Optional drain counter is enabled with FIFO_DRAIN_CNT_EN.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int D_WIDTH_DEF   = 6;
    localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/fifo_drain_buf.sv
// Two-entry ordered head/skid buffer; output is the head register only.
// Latency: a push into an empty buffer is visible after one edge.
// Backpressure: the caller never pushes at OCC_TWO; clr/rst empty it at the edge.
module fifo_drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               push_vld,
    input  logic [D_WIDTH-1:0] push_dat,
    input  logic               xfer,
    output logic [D_WIDTH-1:0] head_dat,
    output occ_t               occ
);

    occ_t               occ_q, occ_d;
    logic [D_WIDTH-1:0] head_q, head_d;
    logic [D_WIDTH-1:0] skid_q, skid_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (rst) begin
            occ_d  = OCC_EMPTY;
            head_d = '0;
            skid_d = '0;
        end else if (clr) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push_vld) begin
                        head_d = push_dat;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    // Head drains while a new word lands: it goes straight to head.
                    if (push_vld && xfer) begin
                        head_d = push_dat;
                    end else if (push_vld) begin
                        skid_d = push_dat;
                        occ_d  = OCC_TWO;
                    end else if (xfer) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (xfer) begin
                        head_d = skid_q;
                        if (push_vld) begin
                            skid_d = push_dat;
                        end else begin
                            occ_d = OCC_ONE;
                        end
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        occ_q  <= occ_d;
        head_q <= head_d;
        skid_q <= skid_d;
    end

    assign head_dat = head_q;
    assign occ      = occ_q;

endmodule

// File: rtl/fifo_drain.sv
// Drains an upstream FIFO into a valid/ready stream; FIFO_DRAIN_CNT_EN adds drain_cnt.
// Latency: one cycle from pop to out_valid when the buffer is empty.
// Backpressure: pops stop at two buffered words; fifo_pop never depends on out_ready.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    input  logic                 flush,
    output logic [D_WIDTH-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] drain_cnt
`endif
);

    occ_t occ;
    logic xfer;

    assign fifo_pop  = !fifo_empty && !flush && !rst && (occ != OCC_TWO);
    assign out_valid = (occ != OCC_EMPTY);
    // Flush and reset both cancel a same-edge transfer, so nothing is counted.
    assign xfer      = out_valid && out_ready && !flush && !rst;

    fifo_drain_buf #(
        .D_WIDTH (D_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (fifo_pop),
        .push_dat (fifo_data),
        .xfer     (xfer),
        .head_dat (out_data),
        .occ      (occ)
    );

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = '0;
        end else if (xfer && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign drain_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: behavioural FIFO + scoreboard plus a vector table.
// Counter checks (including a 2-bit saturating instance) run when FIFO_DRAIN_CNT_EN is set.
module tb_fifo_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       flush;
    logic [5:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int n_xfer = 0;
    logic last_pop;

    logic [5:0] src_q[$];
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] drain_cnt;
    logic [1:0]  drain_cnt2;
    logic [5:0]  out_data2;
    logic        out_valid2;
    logic        fifo_pop2;
    int          cnt_m  = 0;
    int          cnt2_m = 0;
`endif

    fifo_drain dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .drain_cnt  (drain_cnt)
`endif
    );

`ifdef FIFO_DRAIN_CNT_EN
    fifo_drain #(
        .CNT_WIDTH (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop2),
        .flush      (flush),
        .out_data   (out_data2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .drain_cnt  (drain_cnt2)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: present FIFO head, check outputs at negedge, advance the model at the edge.
    task automatic step();
        logic       p;
        logic       x;
        logic       exp_pop;
        logic [5:0] w;
        fifo_empty = (src_q.size() == 0);
        fifo_data  = fifo_empty ? 6'h00 : src_q[0];
        @(negedge clk);
        exp_pop = (src_q.size() != 0) && !flush && !rst && (exp_q.size() < 2);
        chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("out_data", {26'd0, out_data}, {26'd0, exp_q[0]});
        p        = fifo_pop;
        last_pop = fifo_pop;
        x        = (exp_q.size() != 0) && out_ready && !flush && !rst;
        if (rst) begin
            exp_q.delete();
`ifdef FIFO_DRAIN_CNT_EN
            cnt_m  = 0;
            cnt2_m = 0;
`endif
        end else if (flush) begin
            exp_q.delete();
        end else if (x) begin
            void'(exp_q.pop_front());
            n_xfer++;
`ifdef FIFO_DRAIN_CNT_EN
            if (cnt_m < 16'hFFFF) cnt_m++;
            if (cnt2_m < 3) cnt2_m++;
`endif
        end
        if (p === 1'b1 && src_q.size() != 0) begin
            w = src_q.pop_front();
            if (!rst && !flush) exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
`ifdef FIFO_DRAIN_CNT_EN
        chk("drain_cnt", {16'd0, drain_cnt}, cnt_m);
        chk("drain_cnt_w2", {30'd0, drain_cnt2}, cnt2_m);
`endif
    endtask

    typedef struct {
        logic       rdy;
        logic       flsh;
        logic       pop;
        logic       vld;
        logic       chk_dat;
        logic [5:0] dat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int x0;
        // Backpressure fill to two entries, then drain in order.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0A};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0A};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h0A};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h0B};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0C};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00};

        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        src_q.push_back(6'h15);
        fifo_empty = 1'b0;
        fifo_data  = 6'h15;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", {31'd0, fifo_pop}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {26'd0, out_data}, 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
        chk("rst_cnt", {16'd0, drain_cnt}, 32'd0);
`endif

        // Single word, one-cycle latency.
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("first_pop", {31'd0, last_pop}, 32'd1);
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_data", {26'd0, out_data}, 32'h15);
        step();

        // Streaming at one word per cycle.
        x0 = n_xfer;
        for (int i = 1; i <= 5; i++) src_q.push_back(6'(i));
        repeat (6) step();
        chk("stream_xfers", n_xfer - x0, 32'd5);
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        for (int i = 10; i <= 12; i++) src_q.push_back(6'(i));
        for (int i = 0; i < 6; i++) begin
            out_ready = tbl[i].rdy;
            flush     = tbl[i].flsh;
            step();
            chk($sformatf("tbl%0d_pop", i), {31'd0, last_pop}, {31'd0, tbl[i].pop});
            chk($sformatf("tbl%0d_vld", i), {31'd0, out_valid}, {31'd0, tbl[i].vld});
            if (tbl[i].chk_dat) chk($sformatf("tbl%0d_dat", i), {26'd0, out_data}, {26'd0, tbl[i].dat});
        end

        // Flush at full occupancy with a transfer pending.
        out_ready = 1'b0;
        for (int i = 33; i <= 35; i++) src_q.push_back(6'(i));
        repeat (2) step();
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("flush_pop", {31'd0, last_pop}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        repeat (3) step();

        // Reset mid-stream with words buffered.
        out_ready = 1'b0;
        for (int i = 49; i <= 51; i++) src_q.push_back(6'(i));
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {26'd0, out_data}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("end_scoreboard", exp_q.size(), 32'd0);
        chk("end_source", src_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
